// File: rtl/sva_mon_pkg.sv
// rtl/sva_mon_pkg.sv - shared types and defaults for the implication monitor
package sva_mon_pkg;

  localparam int DELAY_MAX   = 8;
  localparam int DEF_DELAY   = 1;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TS_W    = 32;

  // Outcome of the obligation maturing at the current edge
  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_PASS = 2'd1,
    EV_FAIL = 2'd2
  } eval_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, hold at all-ones; clear wins over a same-edge increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/sva_impl_monitor.sv
// rtl/sva_impl_monitor.sv - run-time checker for "ante |=> cons after DELAY clocks"
module sva_impl_monitor
  import sva_mon_pkg::*;
#(
  parameter int DELAY = DEF_DELAY,
  parameter int CNT_W = DEF_CNT_W,
  parameter int TS_W  = DEF_TS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             ante,
  input  logic             cons,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output logic             pending,
  output logic [CNT_W-1:0] attempt_cnt,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_valid,
  output logic [TS_W-1:0]  first_fail_time
);

  if (DELAY < 1 || DELAY > DELAY_MAX) begin : g_bad_delay
    $error("sva_impl_monitor: DELAY=%0d outside 1..%0d", DELAY, DELAY_MAX);
  end

  logic [DELAY-1:0] ob;
  logic [TS_W-1:0]  ts;
  logic             tail;
  logic             start;
  eval_t            ev;

  assign tail    = ob[DELAY-1];
  assign start   = enable & ante;
  assign pending = |ob;

  // Free-running timestamp; clear deliberately leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_W'(1);
    end
  end

  // Obligation pipe: one bit per antecedent match, matures at the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob <= '0;
    end else if (clear) begin
      ob <= '0;
    end else begin
      ob[0] <= start;
      for (int i = 1; i < DELAY; i++) begin
        ob[i] <= ob[i-1];
      end
    end
  end

  // Classify the maturing obligation; clear suppresses the evaluation
  always_comb begin
    ev = EV_NONE;
    if (tail && !clear) begin
      ev = cons ? EV_PASS : EV_FAIL;
    end
  end

  // Registered outcome pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_pulse <= 1'b0;
      fail_pulse <= 1'b0;
    end else begin
      pass_pulse <= (ev == EV_PASS);
      fail_pulse <= (ev == EV_FAIL);
    end
  end

  // Sticky capture of the timestamp of the first failing edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_valid <= 1'b0;
      first_fail_time  <= '0;
    end else if (clear) begin
      first_fail_valid <= 1'b0;
      first_fail_time  <= '0;
    end else if ((ev == EV_FAIL) && !first_fail_valid) begin
      first_fail_valid <= 1'b1;
      first_fail_time  <= ts;
    end
  end

  sat_counter #(.W(CNT_W)) u_attempt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (start),
    .cnt   (attempt_cnt)
  );

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (ev == EV_PASS),
    .cnt   (pass_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (ev == EV_FAIL),
    .cnt   (fail_cnt)
  );

endmodule
